// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard_if
// Purpose  : Groups the ID-stage issue request, the MEM/WB retire report and
//            the returned stall for the register scoreboard.
// Ports    : (interface signals)
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite
//                           - instruction currently in ID
//   wb_retire, wb_rd, wb_regwrite
//                           - instruction leaving MEM/WB (killed ones too)
//   stall                   - hold IF/ID, bubble into ID/EX (combinational)
// Modports : master (pipeline side drives requests), slave (scoreboard)
// Revision : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if #(
  parameter int REG_AW = 5
) ();
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              wb_retire;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic              stall;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
    output wb_retire, wb_rd, wb_regwrite,
    input  stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
    input  wb_retire, wb_rd, wb_regwrite,
    output stall
  );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Tracks in-flight register writes between decode and writeback
//            and stalls ID when a source operand can be supplied neither by
//            the register file nor by MEM/WB forwarding, or when the
//            destination's in-flight counter is saturated.
// Ports    :
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous reset, active-low
//   sb            if   reg_scoreboard_if.slave (ID request, WB retire, stall)
//   pending_any   out  registered: any in-flight counter non-zero
//   sb_err        out  registered, sticky: retire seen on a zero counter
//   stall_cycles  out  registered stall-cycle count (only with STALL_COUNT_EN)
// Config   : define STALL_COUNT_EN to add the 32-bit stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 2
) (
  input  wire                      clk,
  input  wire                      rst_n,
  reg_scoreboard_if.slave          sb,
  output logic                     pending_any,
`ifdef STALL_COUNT_EN
  output logic [31:0]              stall_cycles,
`endif
  output logic                     sb_err
);

  localparam int              c_nreg    = 2 ** REG_AW;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [REG_AW-1:0] c_x0     = '0;

  // Flattened view of all counters; slot 0 (x0) is a hard zero.
  logic [c_nreg*CNT_W-1:0] cnt_flat;
  logic [c_nreg-1:1]       nz_vec;   // counter non-zero after this edge's update
  logic [c_nreg-1:1]       err_vec;  // retire hit a zero counter

  logic             wb_ok;
  logic             fire;
  logic             stall;
  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic [CNT_W-1:0] cnt_rd;
  logic             hit_rs1;
  logic             hit_rs2;
  logic             hit_rd;
  logic             haz_rs1;
  logic             haz_rs2;
  logic             haz_rd;

  logic pending_any_q;
  logic sb_err_q;

  assign cnt_flat[CNT_W-1:0] = '0;

  assign wb_ok   = sb.wb_retire & sb.wb_regwrite;

  assign cnt_rs1 = cnt_flat[int'(sb.id_rs1)*CNT_W +: CNT_W];
  assign cnt_rs2 = cnt_flat[int'(sb.id_rs2)*CNT_W +: CNT_W];
  assign cnt_rd  = cnt_flat[int'(sb.id_rd)*CNT_W +: CNT_W];

  assign hit_rs1 = wb_ok & (sb.wb_rd == sb.id_rs1) & (sb.id_rs1 != c_x0);
  assign hit_rs2 = wb_ok & (sb.wb_rd == sb.id_rs2) & (sb.id_rs2 != c_x0);
  assign hit_rd  = wb_ok & (sb.wb_rd == sb.id_rd)  & (sb.id_rd  != c_x0);

  // A single outstanding write that is retiring right now is forwarded from
  // MEM/WB, so it does not block the reader.
  assign haz_rs1 = sb.id_use_rs1 & (sb.id_rs1 != c_x0) & (cnt_rs1 != '0)
                 & ~(hit_rs1 & (cnt_rs1 == c_cnt_one));
  assign haz_rs2 = sb.id_use_rs2 & (sb.id_rs2 != c_x0) & (cnt_rs2 != '0)
                 & ~(hit_rs2 & (cnt_rs2 == c_cnt_one));
  // A saturated counter may still accept an issue if one write retires in
  // the same cycle (net change zero), so overflow is impossible.
  assign haz_rd  = sb.id_regwrite & (sb.id_rd != c_x0) & (cnt_rd == c_cnt_max)
                 & ~hit_rd;

  assign stall    = sb.id_valid & (haz_rs1 | haz_rs2 | haz_rd);
  assign sb.stall = stall;
  assign fire     = sb.id_valid & ~stall & sb.id_regwrite & (sb.id_rd != c_x0);

  for (genvar r = 1; r < c_nreg; r++) begin : g_cnt
    localparam logic [REG_AW-1:0] c_idx = REG_AW'(r);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hit;
    logic             inc;

    assign hit = wb_ok & (sb.wb_rd == c_idx);
    assign inc = fire & (sb.id_rd == c_idx);

    // Issue and retire together cancel; a retire on zero saturates at zero.
    assign cnt_d = (inc & ~hit)                    ? cnt_q + c_cnt_one :
                   (hit & ~inc & (cnt_q != '0))   ? cnt_q - c_cnt_one :
                                                    cnt_q;

    assign err_vec[r] = hit & ~inc & (cnt_q == '0);
    assign nz_vec[r]  = |cnt_d;
    assign cnt_flat[r*CNT_W +: CNT_W] = cnt_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_any_q <= 1'b0;
      sb_err_q      <= 1'b0;
    end else begin
      pending_any_q <= |nz_vec;
      sb_err_q      <= sb_err_q | (|err_vec);
    end
  end

  assign pending_any = pending_any_q;
  assign sb_err      = sb_err_q;

`ifdef STALL_COUNT_EN
  logic [31:0] stall_cycles_q;

  // Free-running; wraps naturally from all-ones to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else if (stall) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Purpose  : Directed self-checking bench for reg_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

  logic clk;
  logic rst_n;
  logic pending_any;
  logic sb_err;
`ifdef STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks;
  int n_fail;

  reg_scoreboard_if #(.REG_AW(5)) u_if ();

  reg_scoreboard #(.REG_AW(5), .CNT_W(2)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sb           (u_if.slave),
    .pending_any  (pending_any),
`ifdef STALL_COUNT_EN
    .stall_cycles (stall_cycles),
`endif
    .sb_err       (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    u_if.id_valid    = 1'b0;
    u_if.id_rs1      = 5'd0;
    u_if.id_rs2      = 5'd0;
    u_if.id_use_rs1  = 1'b0;
    u_if.id_use_rs2  = 1'b0;
    u_if.id_rd       = 5'd0;
    u_if.id_regwrite = 1'b0;
    u_if.wb_retire   = 1'b0;
    u_if.wb_rd       = 5'd0;
    u_if.wb_regwrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    u_if.id_valid    = 1'b1;
    u_if.id_rd       = rd;
    u_if.id_regwrite = 1'b1;
  endtask

  task automatic read1(input logic [4:0] rs);
    u_if.id_valid   = 1'b1;
    u_if.id_rs1     = rs;
    u_if.id_use_rs1 = 1'b1;
  endtask

  task automatic retire(input logic [4:0] rd);
    u_if.wb_retire   = 1'b1;
    u_if.wb_rd       = rd;
    u_if.wb_regwrite = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("rst_pending", pending_any, 0);
    check_eq("rst_err", sb_err, 0);
    check_eq("rst_stall", u_if.stall, 0);

    // Issue to x5, then a reader of x5 must stall.
    issue(5'd5);
    #1 check_eq("t1_issue_stall", u_if.stall, 0);
    tick();
    check_eq("t1_pending", pending_any, 1);
    idle();
    read1(5'd5);
    #1 check_eq("t1_raw_stall", u_if.stall, 1);

    // Same-cycle retire of the only outstanding write: forwarded, no stall.
    retire(5'd5);
    #1 check_eq("t2_fwd_stall", u_if.stall, 0);
    tick();
    check_eq("t2_pending", pending_any, 0);
    idle();
    read1(5'd5);
    #1 check_eq("t2_clear_stall", u_if.stall, 0);
    idle();

    // Three writes to x7 saturate the counter.
    for (int i = 0; i < 3; i++) begin
      issue(5'd7);
      #1 check_eq("t3_issue_stall", u_if.stall, 0);
      tick();
    end
    check_eq("t3_pending", pending_any, 1);
    #1 check_eq("t3_full_stall", u_if.stall, 1);
    retire(5'd7);
    #1 check_eq("t3_full_retire_stall", u_if.stall, 0);
    tick();
    idle();
    issue(5'd7);
    #1 check_eq("t3_still_full", u_if.stall, 1);
    // Forwarding exception only applies when exactly one write is in flight.
    idle();
    read1(5'd7);
    retire(5'd7);
    #1 check_eq("t3_multi_raw", u_if.stall, 1);
    idle();
    retire(5'd7);
    tick();
    tick();
    check_eq("t3_drain_pending", pending_any, 1);
    tick();
    idle();
    check_eq("t3_drained", pending_any, 0);
    check_eq("t3_no_err", sb_err, 0);

    // x0 is never tracked.
    u_if.id_valid    = 1'b1;
    u_if.id_use_rs1  = 1'b1;
    u_if.id_use_rs2  = 1'b1;
    u_if.id_regwrite = 1'b1;
    #1 check_eq("t4_x0_stall", u_if.stall, 0);
    tick();
    tick();
    check_eq("t4_x0_stall2", u_if.stall, 0);
    check_eq("t4_x0_pending", pending_any, 0);
    idle();

    // Retire on an empty counter sets a sticky error.
    retire(5'd9);
    tick();
    idle();
    check_eq("t5_err", sb_err, 1);
    check_eq("t5_pending", pending_any, 0);
    tick();
    tick();
    check_eq("t5_err_sticky", sb_err, 1);

    // Two writes to x3, then stall a reader for three cycles and reset.
    issue(5'd3);
    tick();
    tick();
    idle();
    read1(5'd3);
    #1 check_eq("t6_stall", u_if.stall, 1);
    tick();
    tick();
    tick();
    check_eq("t6_pending", pending_any, 1);
    check_eq("t6_err_kept", sb_err, 1);
`ifdef STALL_COUNT_EN
    check_eq("t6_stall_cycles", stall_cycles, 3);
`endif
    u_if.id_regwrite = 1'b1;
    u_if.id_rd       = 5'd3;
    rst_n = 1'b0;
    tick();
    check_eq("t6_rst_stall", u_if.stall, 0);
    check_eq("t6_rst_pending", pending_any, 0);
    check_eq("t6_rst_err", sb_err, 0);
`ifdef STALL_COUNT_EN
    check_eq("t6_rst_stall_cycles", stall_cycles, 0);
`endif
    idle();
    rst_n = 1'b1;
    tick();
    check_eq("t6_post_pending", pending_any, 0);
    read1(5'd3);
    #1 check_eq("t6_post_stall", u_if.stall, 0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
